spike_rate_encoder: RTL
=======================

# spike_rate_encoder

Rate-coding spike encoder sitting upstream of the fixed-point LIF neurons: it accepts one unsigned intensity sample per window over a valid/ready handshake and emits a deterministic binary spike train (one bit per clock) for WINDOW cycles. The spike rate is proportional to the intensity. `spike` drives a neuron's binary `input_spike` directly. `spike_count` and `done` let the controller and the bench check the encoded rate without a separate counter.

## Interface
- `VAL_W`, default 8: intensity width. Full scale is 2^VAL_W, so value v encodes a rate of v/2^VAL_W spikes per cycle.
- `WINDOW`, default 16: encode cycles per sample. Legal range is 2 to 2^VAL_W.
- `CNT_W`, default `$clog2(WINDOW+1)`: width of `spike_count`.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: `in_value` is valid.
- `in_ready`, output, 1: the encoder can accept a sample this cycle.
- `in_value`, input, VAL_W: unsigned intensity.
- `spike`, output, 1: registered spike bit for the current window cycle.
- `busy`, output, 1: high for the whole encode window.
- `done`, output, 1: one-cycle pulse in the last window cycle.
- `spike_count`, output, CNT_W: running count of spikes in the current or last window.

## Operation
- **States.**
  - IDLE: no window active.
  - ENCODE: window active. Phase counter `ph` runs 1..WINDOW.
- **Accept.** A sample is accepted when `in_valid && in_ready` is high at a rising edge.
- **`in_ready`.** It is combinational: `in_ready = (state==IDLE) || (state==ENCODE && ph==WINDOW)`.
- **On accept:**
  - latch `in_value` into `val_q`;
  - clear accumulator `acc` (VAL_W bits) to 0;
  - set `ph` to 1 and state to ENCODE;
  - compute the first addition in the same edge, as in the per-cycle update below.
- **Per encode cycle, using k-th addition:**
  - `sum = acc + val_q`, held in VAL_W+1 bits with no truncation;
  - `spike <= sum[VAL_W]` (the carry bit);
  - `acc <= sum[VAL_W-1:0]` (wraps modulo 2^VAL_W).
- **Spike total.** Spikes per window equal `floor(v*WINDOW / 2^VAL_W)`. v=0 gives no spikes. With defaults, v=255 gives 15 spikes.
- **`spike_count`.**
  - Cleared on accept, and then updated with the first spike: it equals `spike` at window cycle 1.
  - Increments by 1 in every cycle where `spike` is 1, so it always includes the current `spike`.
  - Holds its final value after the window until the next accept.
  - It cannot overflow, because spikes never exceed WINDOW-1.
- **End of window.** When `ph==WINDOW` at an edge and there is no accept, go to IDLE and set `spike`, `busy` and `done` to 0.
- **Back-to-back.** An accept during `ph==WINDOW` starts the new window on the next edge with `acc` cleared. There is no idle gap, and `busy` stays 1.
- **`in_value`** is ignored when there is no handshake. `in_valid` during ENCODE with `ph<WINDOW` is stalled, because `in_ready` is 0.
- **Reset, at any time including mid-window:**
  - state goes to IDLE;
  - `spike`, `busy`, `done`, `spike_count`, `acc`, `val_q` and `ph` go to 0;
  - the partial window is discarded.

## Timing
- **Window timing.** For an accept at edge T, window cycle k (k=1..WINDOW) is the cycle after edge T+k-1.
  - `spike`, `busy` and `ph=k` are valid in window cycle k.
  - Latency from accept to the first spike slot is 1 cycle.
- **`done`.** It is high only in window cycle WINDOW, together with the last spike slot and the final `spike_count`.
- **Throughput.** One sample per WINDOW cycles, sustained with back-to-back accepts.
- **Reset values.** `spike`=0, `busy`=0, `done`=0, `spike_count`=0. `in_ready`=1 whenever `rst` is high and after reset, since the state is IDLE.

## Test plan
All scenarios use defaults (VAL_W=8, WINDOW=16).
- **v=128:** accept 128 → spikes in window cycles 2,4,…,16, `spike_count`=8 with `done`, then `busy`=0 and `in_ready`=1.
- **v=255:** accept 255 → spikes in cycles 2..16, cycle 1 has no spike, and `spike_count`=15 at `done`.
- **v=16 and v=0:**
  - 16 gives a single spike at cycle 16 and count 1;
  - 0 gives no spikes, `done` still pulses at cycle 16, and count 0.
- **Back-to-back:** 128, then 64 presented with `in_valid` held high → 64 is accepted at `ph`=16 with no gap. The second window has spikes at cycles 4,8,12,16 and count 4. `busy` stays high for 32 cycles and `done` pulses twice.
- **Stall:** hold `in_valid` with 200 during cycles 3..16 of a window → `in_ready`=0 until cycle 16, and exactly one accept occurs.
- **Reset mid-window:** assert `rst` asynchronously in cycle 5 of v=128 → `spike`, `busy`, `done` and `spike_count` go to 0 immediately and `in_ready`=1. The next accept of 128 reproduces the exact v=128 pattern.

Source files
------------

// File: rtl/spike_rate_encoder.sv
// Rate-coding spike encoder: one intensity sample per WINDOW-cycle window, emitted as a
// deterministic spike train from the carry of a phase accumulator.
module spike_rate_encoder #(
  parameter int VAL_W  = 8,
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  output logic             spike,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] spike_count
);

  localparam int PH_W = $clog2(WINDOW + 1);

  typedef enum logic {S_IDLE, S_ENCODE} state_t;

  state_t           r_state, w_nxt_state;
  logic [PH_W-1:0]  r_ph, w_nxt_ph;
  logic [VAL_W-1:0] r_acc, w_nxt_acc;
  logic [VAL_W-1:0] r_val, w_nxt_val;
  logic             r_spike, w_nxt_spike;
  logic             r_busy, w_nxt_busy;
  logic             r_done, w_nxt_done;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;

  logic             w_last, w_accept;
  logic [VAL_W-1:0] w_add_a, w_add_b;
  logic [VAL_W:0]   w_sum;

  assign w_last   = (r_state == S_ENCODE) && (r_ph == PH_W'(WINDOW));
  assign in_ready = (r_state == S_IDLE) || w_last;
  assign w_accept = in_valid && in_ready;

  // On accept the first addition starts from a cleared accumulator and the new sample.
  assign w_add_a = w_accept ? '0 : r_acc;
  assign w_add_b = w_accept ? in_value : r_val;
  assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b};

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ph    = r_ph;
    w_nxt_acc   = r_acc;
    w_nxt_val   = r_val;
    w_nxt_spike = r_spike;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    w_nxt_cnt   = r_cnt;
    if (w_accept) begin
      w_nxt_state = S_ENCODE;
      w_nxt_val   = in_value;
      w_nxt_acc   = w_sum[VAL_W-1:0];
      w_nxt_ph    = PH_W'(1);
      w_nxt_spike = w_sum[VAL_W];
      w_nxt_busy  = 1'b1;
      w_nxt_cnt   = CNT_W'(w_sum[VAL_W]);
    end else if (r_state == S_ENCODE) begin
      if (w_last) begin
        w_nxt_state = S_IDLE;
        w_nxt_ph    = '0;
        w_nxt_spike = 1'b0;
        w_nxt_busy  = 1'b0;
      end else begin
        w_nxt_acc   = w_sum[VAL_W-1:0];
        w_nxt_ph    = r_ph + PH_W'(1);
        w_nxt_spike = w_sum[VAL_W];
        w_nxt_cnt   = r_cnt + CNT_W'(w_sum[VAL_W]);
        w_nxt_done  = (r_ph + PH_W'(1)) == PH_W'(WINDOW);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_acc   <= '0;
      r_val   <= '0;
      r_spike <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_ph    <= w_nxt_ph;
      r_acc   <= w_nxt_acc;
      r_val   <= w_nxt_val;
      r_spike <= w_nxt_spike;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      r_cnt   <= w_nxt_cnt;
    end
  end

  assign spike       = r_spike;
  assign busy        = r_busy;
  assign done        = r_done;
  assign spike_count = r_cnt;

endmodule
